// File: rtl/cpu_step_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_if
// Description : Monitor <-> step controller bundle: step/run commands, CPU
//               debug status in, tick enable and status/counters out.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_step_if #(
    parameter int CNT_W = 16
) ();
    logic             cmd_cycle;
    logic             cmd_insn;
    logic             cmd_run;
    logic             cmd_stop;
    logic             clear_counts;
    logic             dbg_F0;
    logic             dbg_halt;
    logic             cpu_tick;
    logic             busy;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] insn_count;

    modport master (
        output cmd_cycle, cmd_insn, cmd_run, cmd_stop, clear_counts,
        output dbg_F0, dbg_halt,
        input  cpu_tick, busy, halted, timeout, cycle_count, insn_count
    );

    modport slave (
        input  cmd_cycle, cmd_insn, cmd_run, cmd_stop, clear_counts,
        input  dbg_F0, dbg_halt,
        output cpu_tick, busy, halted, timeout, cycle_count, insn_count
    );
endinterface
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller
// Description : Owns the CPU advance enable; single-cycle, single-instruction
//               and free-run stepping with halt detection and watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_controller #(
    parameter int RUN_DIV   = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_TICKS = 64
) (
    input  wire logic  clock,
    input  wire logic  reset,
    cpu_step_if.slave  bus
);
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam int WAIT_W    = $clog2(RUN_DIV + 1);
    localparam int WAIT_LAST = (RUN_DIV > 2) ? (RUN_DIV - 3) : 0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TICK     = 3'd1,
        S_SAMPLE   = 3'd2,
        S_RUN_WAIT = 3'd3,
        S_HALTED   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        M_CYCLE = 2'd0,
        M_INSN  = 2'd1,
        M_RUN   = 2'd2
    } mode_t;

    state_t             state_q,   state_d;
    mode_t              mode_q,    mode_d;
    logic [TICK_W-1:0]  tcnt_q,    tcnt_d;
    logic [WAIT_W-1:0]  wcnt_q,    wcnt_d;
    logic               stop_q,    stop_d;
    logic               timeout_q, timeout_d;
    logic               tick_q,    tick_d;
    logic [CNT_W-1:0]   ccnt_q,    ccnt_d;
    logic [CNT_W-1:0]   icnt_q,    icnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= M_CYCLE;
            tcnt_q    <= '0;
            wcnt_q    <= '0;
            stop_q    <= 1'b0;
            timeout_q <= 1'b0;
            tick_q    <= 1'b0;
            ccnt_q    <= '0;
            icnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tcnt_q    <= tcnt_d;
            wcnt_q    <= wcnt_d;
            stop_q    <= stop_d;
            timeout_q <= timeout_d;
            tick_q    <= tick_d;
            ccnt_q    <= ccnt_d;
            icnt_q    <= icnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tcnt_d    = tcnt_q;
        wcnt_d    = wcnt_q;
        stop_d    = stop_q;
        timeout_d = timeout_q;
        ccnt_d    = ccnt_q;
        icnt_d    = icnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.dbg_halt) begin
                    state_d = S_HALTED;
                end else if (bus.cmd_insn || bus.cmd_cycle || bus.cmd_run) begin
                    mode_d    = bus.cmd_insn  ? M_INSN  :
                                bus.cmd_cycle ? M_CYCLE : M_RUN;
                    state_d   = S_TICK;
                    tcnt_d    = '0;
                    stop_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end

            S_TICK: begin
                ccnt_d  = ccnt_q + CNT_W'(1);
                tcnt_d  = tcnt_q + TICK_W'(1);
                state_d = S_SAMPLE;
                if (bus.cmd_stop) stop_d = 1'b1;
            end

            // CPU state after the tick is visible here; first matching rule wins.
            S_SAMPLE: begin
                if (bus.dbg_F0) icnt_d = icnt_q + CNT_W'(1);
                if (bus.dbg_halt) begin
                    state_d = S_HALTED;
                end else if (stop_q || bus.cmd_stop) begin
                    state_d = S_IDLE;
                end else begin
                    case (mode_q)
                        M_CYCLE: state_d = S_IDLE;
                        M_INSN: begin
                            if (bus.dbg_F0) begin
                                state_d = S_IDLE;
                            end else if (tcnt_q == TICK_W'(MAX_TICKS)) begin
                                state_d   = S_IDLE;
                                timeout_d = 1'b1;
                            end else begin
                                state_d = S_TICK;
                            end
                        end
                        default: begin
                            wcnt_d  = '0;
                            state_d = (RUN_DIV > 2) ? S_RUN_WAIT : S_TICK;
                        end
                    endcase
                end
            end

            // TICK and SAMPLE take two clocks; the rest of RUN_DIV is spent here.
            S_RUN_WAIT: begin
                if (bus.cmd_stop) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WAIT_W'(WAIT_LAST)) begin
                    state_d = S_TICK;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end

            S_HALTED: begin
                if (!bus.dbg_halt) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        if (bus.clear_counts) begin
            ccnt_d = '0;
            icnt_d = '0;
        end
    end

    // Registered tick lines up exactly with the TICK state.
    assign tick_d = (state_d == S_TICK);

    assign bus.cpu_tick    = tick_q;
    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign bus.halted      = (state_q == S_HALTED);
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = ccnt_q;
    assign bus.insn_count  = icnt_q;
endmodule
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_controller
// Description : Directed bench with a tick-time scoreboard and a small
//               F0->F1->E0 CPU model for cpu_step_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_controller;
    localparam int CNT_W = 8;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cpu_step_if #(.CNT_W(CNT_W)) ifc ();

    cpu_step_controller #(
        .RUN_DIV   (4),
        .CNT_W     (CNT_W),
        .MAX_TICKS (64)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_q[$];
    logic prev_tick = 1'b0;

    // CPU model: F0 -> F1 -> E0 -> F0, advancing once per tick
    logic [1:0] cpu_st;
    logic       cpu_clr;
    int         f0_mode;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cpu_clr)           cpu_st <= 2'd0;
        else if (ifc.cpu_tick) cpu_st <= (cpu_st == 2'd2) ? 2'd0 : cpu_st + 2'd1;
    end
    assign ifc.dbg_F0 = (f0_mode == 1) ? 1'b1 : (f0_mode == 2) ? 1'b0 : (cpu_st == 2'd0);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every tick must match the next expected cycle stamp.
    always @(negedge clock) begin
        int e;
        if (ifc.cpu_tick) begin
            checks++;
            assert (!prev_tick) else begin
                errors++;
                $error("FAIL tick_back_to_back observed=1 expected=0 at cycle %0d", cyc);
            end
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL tick_unexpected observed=tick expected=none at cycle %0d", cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tick_time", cyc, e);
            end
        end
        prev_tick = ifc.cpu_tick;
    end

    task automatic pulse(input int which);
        case (which)
            0: ifc.cmd_cycle = 1'b1;
            1: ifc.cmd_insn  = 1'b1;
            2: ifc.cmd_run   = 1'b1;
            default: ifc.cmd_stop = 1'b1;
        endcase
        @(negedge clock);
        ifc.cmd_cycle = 1'b0;
        ifc.cmd_insn  = 1'b0;
        ifc.cmd_run   = 1'b0;
        ifc.cmd_stop  = 1'b0;
    endtask

    task automatic clr();
        ifc.clear_counts = 1'b1;
        cpu_clr          = 1'b1;
        @(negedge clock);
        ifc.clear_counts = 1'b0;
        cpu_clr          = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (ifc.busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        assert (!ifc.busy) else begin
            errors++;
            $error("FAIL %s observed=busy expected=idle within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        int k;
        reset            = 1'b1;
        cpu_clr          = 1'b1;
        f0_mode          = 1;
        ifc.cmd_cycle    = 1'b0;
        ifc.cmd_insn     = 1'b0;
        ifc.cmd_run      = 1'b0;
        ifc.cmd_stop     = 1'b0;
        ifc.clear_counts = 1'b0;
        ifc.dbg_halt     = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tick",    ifc.cpu_tick, 0);
        check("rst_busy",    ifc.busy, 0);
        check("rst_halted",  ifc.halted, 0);
        check("rst_timeout", ifc.timeout, 0);
        check("rst_ccnt",    ifc.cycle_count, 0);
        check("rst_icnt",    ifc.insn_count, 0);
        reset   = 1'b0;
        cpu_clr = 1'b0;
        @(negedge clock);

        // single cycle step with F0 held high
        k = cyc; exp_q.push_back(k + 1);
        pulse(0);
        @(negedge clock);
        check("cyc_ccnt", ifc.cycle_count, 1);
        check("cyc_busy", ifc.busy, 1);
        @(negedge clock);
        check("cyc_icnt", ifc.insn_count, 1);
        check("cyc_idle", ifc.busy, 0);

        // instruction step through F1, E0 back to F0
        clr();
        f0_mode = 0;
        k = cyc; exp_q.push_back(k + 1); exp_q.push_back(k + 3); exp_q.push_back(k + 5);
        pulse(1);
        repeat (6) @(negedge clock);
        check("insn_idle", ifc.busy, 0);
        check("insn_ccnt", ifc.cycle_count, 3);
        check("insn_icnt", ifc.insn_count, 1);
        check("insn_f0",   ifc.dbg_F0, 1);

        // free run, halt after the fifth tick
        clr();
        f0_mode = 1;
        k = cyc;
        for (int i = 0; i < 5; i++) exp_q.push_back(k + 1 + 4 * i);
        pulse(2);
        repeat (16) @(negedge clock);
        ifc.dbg_halt = 1'b1;
        repeat (2) @(negedge clock);
        check("halt_halted", ifc.halted, 1);
        check("halt_busy",   ifc.busy, 0);
        pulse(0);
        repeat (3) @(negedge clock);
        check("halt_ignore", ifc.halted, 1);
        check("halt_ccnt",   ifc.cycle_count, 5);
        ifc.dbg_halt = 1'b0;
        repeat (2) @(negedge clock);
        check("halt_exit", ifc.halted, 0);

        // watchdog on an instruction step that never reaches F0
        clr();
        f0_mode = 2;
        k = cyc;
        for (int i = 0; i < 64; i++) exp_q.push_back(k + 1 + 2 * i);
        pulse(1);
        wait_idle(300, "wdog_idle");
        check("wdog_timeout", ifc.timeout, 1);
        check("wdog_ccnt",    ifc.cycle_count, 64);
        f0_mode = 1;
        exp_q.push_back(cyc + 1);
        pulse(0);
        check("wdog_clear", ifc.timeout, 0);
        repeat (2) @(negedge clock);

        // stop during RUN_WAIT: no further tick
        clr();
        k = cyc; exp_q.push_back(k + 1);
        pulse(2);
        repeat (2) @(negedge clock);
        pulse(3);
        repeat (8) @(negedge clock);
        check("stopw_idle", ifc.busy, 0);
        check("stopw_ccnt", ifc.cycle_count, 1);

        // stop in a tick cycle: that tick only
        k = cyc; exp_q.push_back(k + 1); exp_q.push_back(k + 5);
        pulse(2);
        repeat (4) @(negedge clock);
        pulse(3);
        repeat (8) @(negedge clock);
        check("stopt_idle", ifc.busy, 0);
        check("stopt_ccnt", ifc.cycle_count, 3);

        // counter wrap
        clr();
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back(cyc + 1);
            pulse(0);
            repeat (2) @(negedge clock);
        end
        check("wrap_ccnt_max", ifc.cycle_count, 255);
        check("wrap_icnt_max", ifc.insn_count, 255);
        exp_q.push_back(cyc + 1);
        pulse(0);
        repeat (2) @(negedge clock);
        check("wrap_ccnt_zero", ifc.cycle_count, 0);
        check("wrap_icnt_zero", ifc.insn_count, 0);

        // clear_counts beats same-cycle increments
        exp_q.push_back(cyc + 1);
        pulse(0);
        ifc.clear_counts = 1'b1;
        @(negedge clock);
        check("clr_ccnt", ifc.cycle_count, 0);
        @(negedge clock);
        ifc.clear_counts = 1'b0;
        check("clr_icnt",  ifc.insn_count, 0);
        check("clr_ccnt2", ifc.cycle_count, 0);

        // reset in the clock before a RUN tick
        exp_q.push_back(cyc + 1);
        pulse(2);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mrst_tick",   ifc.cpu_tick, 0);
        check("mrst_busy",   ifc.busy, 0);
        check("mrst_halted", ifc.halted, 0);
        check("mrst_timeout", ifc.timeout, 0);
        check("mrst_ccnt",   ifc.cycle_count, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
